// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with
// one word per line. Lines, tags and valid bits are held in flops.
//
// Both sides use the same handshake: a transfer completes in the cycle that
// rd or wr is high and waitrequest is low. Read data is valid in that cycle.
// A read miss fills the line and returns to IDLE. The requester then retries,
// and the retry hits.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   cache_addr/rd/wr/wr_data, cache_data, cache_waitrequest
//                        pipeline-side request/response
//   mem_addr/rd/wr/wr_data, mem_data, mem_waitrequest
//                        backing-memory request/response
//   hit_count, miss_count
//                        statistics. They are real counters only when
//                        DCACHE_STATS_EN is defined; otherwise they are tied to 0.
//
// Optional feature macro: DCACHE_STATS_EN
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | serve read hits with zero wait states; accept new requests
// FILL  | read the missing word from memory, then install it in the line
// WRITE | write the word through to memory; update the line only on a hit
module dcache_wt #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [DATA_WIDTH-1:0] cache_data,
    output logic                  cache_waitrequest,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_waitrequest,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   line_q [LINES];

    logic [INDEX_BITS-1:0]   req_index, lat_index;
    logic [TAG_W-1:0]        req_tag, lat_tag;
    logic                    req_hit, lat_hit;
    logic                    latch_req, fill_done, write_done;

    assign req_index = cache_addr[INDEX_BITS+1:2];
    assign req_tag   = cache_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lat_index = addr_q[INDEX_BITS+1:2];
    assign lat_tag   = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign req_hit   = valid_q[req_index] && (tag_q[req_index] == req_tag);
    // The write-hit decision is taken at completion time, against the latched address.
    assign lat_hit   = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        cache_waitrequest = 1'b0;
        cache_data        = '0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_wr_data       = '0;
        latch_req         = 1'b0;
        fill_done         = 1'b0;
        write_done        = 1'b0;
        case (state_q)
            IDLE: begin
                // A write has priority, so rd and wr together is a write.
                if (cache_wr) begin
                    cache_waitrequest = 1'b1;
                    latch_req         = 1'b1;
                    state_d           = WRITE;
                end else if (cache_rd) begin
                    if (req_hit) begin
                        cache_data = line_q[req_index];
                    end else begin
                        cache_waitrequest = 1'b1;
                        latch_req         = 1'b1;
                        state_d           = FILL;
                    end
                end
            end
            FILL: begin
                // The requester always retries after a fill, so the read never completes here.
                mem_rd            = 1'b1;
                mem_addr          = addr_q;
                cache_waitrequest = 1'b1;
                if (!mem_waitrequest) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                mem_wr            = 1'b1;
                mem_addr          = addr_q;
                mem_wr_data       = wdata_q;
                cache_waitrequest = mem_waitrequest;
                if (!mem_waitrequest) begin
                    write_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch_req) begin
            addr_q  <= cache_addr;
            wdata_q <= cache_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)          valid_q            <= '0;
        else if (fill_done) valid_q[lat_index] <= 1'b1;
    end

    // Tag and data storage needs no reset, because valid_q qualifies it.
    // Gating with reset drops a transfer that completes in the reset cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (fill_done) begin
                tag_q[lat_index]  <= lat_tag;
                line_q[lat_index] <= mem_data;
            end else if (write_done && lat_hit) begin
                line_q[lat_index] <= wdata_q;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic rd_hit, fill_start;

    assign rd_hit     = (state_q == IDLE) && cache_rd && !cache_wr && req_hit;
    assign fill_start = (state_q == IDLE) && cache_rd && !cache_wr && !req_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit)     hit_count  <= hit_count + 32'd1;
            if (fill_start) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed bench for dcache_wt (default parameters).
// The reference model holds the backing-memory contents and which words are
// resident, indexed by line. A read must return the current memory word; a
// resident word hits with zero waits; anything else costs a fill.
module tb_dcache_wt;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cache_addr, cache_wr_data, cache_data;
    logic        cache_rd, cache_wr, cache_waitrequest;
    logic [31:0] mem_addr, mem_wr_data, mem_data;
    logic        mem_rd, mem_wr, mem_waitrequest;
    logic [31:0] hit_count, miss_count;

    always #5 clock = ~clock;

    dcache_wt dut (
        .clock(clock), .reset(reset),
        .cache_addr(cache_addr), .cache_rd(cache_rd), .cache_wr(cache_wr),
        .cache_wr_data(cache_wr_data), .cache_data(cache_data),
        .cache_waitrequest(cache_waitrequest),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wr_data(mem_wr_data), .mem_data(mem_data),
        .mem_waitrequest(mem_waitrequest),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int total = 0;
    int bad   = 0;
    int mem_lat = 0;
    int wcnt = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    logic [31:0] mem_model [int];
    bit   [63:0] mvalid;
    logic [23:0] mtag [64];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (mem_model.exists(k)) return mem_model[k];
        return {a[15:0], 16'h5A5A} ^ 32'h0F0F_0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_counts();
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, exp_hit);
        check("miss_count", miss_count, exp_miss);
`else
        check("hit_count_tied", hit_count, 32'd0);
        check("miss_count_tied", miss_count, 32'd0);
`endif
    endtask

    // Memory responder. It drives after each edge and does its accounting at the negedge.
    always @(posedge clock) begin
        automatic logic rst_seen = reset;
        #1;
        if (rst_seen) begin
            wcnt   = 0;
            mvalid = '0;
        end
        if ((mem_rd || mem_wr) && wcnt >= mem_lat) begin
            mem_waitrequest = 1'b0;
            mem_data        = mem_rd ? mem_word(mem_addr) : 32'hA5A5_A5A5;
        end else begin
            mem_waitrequest = 1'b1;
            mem_data        = 32'hA5A5_A5A5;
        end
    end

    always @(negedge clock) begin
        if (!reset && (mem_rd || mem_wr)) begin
            if (!mem_waitrequest) begin
                if (mem_wr) mem_model[int'(mem_addr >> 2)] = mem_wr_data;
                if (mem_rd) begin
                    mvalid[mem_addr[7:2]] = 1'b1;
                    mtag[mem_addr[7:2]]   = mem_addr[31:8];
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Per-cycle compare process against the model.
    always @(negedge clock) begin
        if (!reset) begin
            check("mem_rd_wr_excl", {31'd0, mem_rd && mem_wr}, 32'd0);
            if (cache_rd && !cache_wr && !cache_waitrequest)
                check("rd_data", cache_data, mem_word(cache_addr));
            else
                check("data_zero", cache_data, 32'd0);
            if (!cache_rd && !cache_wr)
                check("mem_idle", {30'd0, mem_rd, mem_wr}, 32'd0);
            if (mem_rd)
                check("fill_addr", mem_addr, cache_addr);
            if (mem_wr) begin
                check("wr_addr", mem_addr, cache_addr);
                check("wr_data", mem_wr_data, cache_wr_data);
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output int waits, output int nrd);
        bit hit_exp, done;
        int lat;
        hit_exp = mvalid[addr[7:2]] && (mtag[addr[7:2]] == addr[31:8]);
        lat = mem_lat;
        cache_addr = addr;
        cache_rd = 1'b1;
        waits = 0; nrd = 0; done = 0; data = '0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (mem_rd) nrd++;
            if (!cache_waitrequest) begin
                data = cache_data;
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL rd_timeout: addr %h got no completion want completion", addr);
        end
        @(posedge clock); #1;
        cache_rd = 1'b0;
        if (hit_exp) begin
            exp_hit++;
            check("hit_waits", waits, 32'd0);
            check("hit_no_fill", nrd, 32'd0);
        end else begin
            exp_miss++;
            exp_hit++;
            check("miss_waits", waits, lat + 2);
            check("miss_fill_cycles", nrd, lat + 1);
        end
        check_counts();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input bit both, output int waits);
        bit done;
        int lat, nwr;
        lat = mem_lat;
        cache_addr = addr;
        cache_wr_data = data;
        cache_wr = 1'b1;
        cache_rd = both;
        waits = 0; nwr = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (mem_wr) nwr++;
            if (!cache_waitrequest) done = 1;
            else waits++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL wr_timeout: addr %h got no completion want completion", addr);
        end
        @(posedge clock); #1;
        cache_wr = 1'b0;
        cache_rd = 1'b0;
        check("wr_waits", waits, lat + 1);
        check("wr_mem_cycles", nwr, lat + 1);
        check_counts();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int w, n;
        reset = 1'b1;
        cache_addr = '0; cache_wr_data = '0; cache_rd = 1'b0; cache_wr = 1'b0;
        mem_data = '0; mem_waitrequest = 1'b1;
        mvalid = '0;
        mem_model[int'(32'h100 >> 2)] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clock);
        #1;
        check("rst_waitreq", {31'd0, cache_waitrequest}, 32'd0);
        check("rst_mem_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        check("rst_cache_data", cache_data, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        reset = 1'b0;

        // Read miss with three memory waits.
        mem_lat = 3;
        do_read(32'h100, d, w, n);
        check("r100_data", d, 32'hDEAD_BEEF);
        check("r100_memrd_cycles", n, 32'd4);
`ifdef DCACHE_STATS_EN
        check("r100_counts", {hit_count[15:0], miss_count[15:0]}, 32'h0001_0001);
`endif
        // A repeat of the same read hits.
        do_read(32'h100, d, w, n);
        check("r100_hit_data", d, 32'hDEAD_BEEF);
        check("r100_hit_waits", w, 32'd0);

        // A write-through hit updates the line.
        mem_lat = 0;
        do_write(32'h100, 32'h1234_5678, 1'b0, w);
        check("w100_waits", w, 32'd1);
        do_read(32'h100, d, w, n);
        check("r100_after_wr", d, 32'h1234_5678);
        check("r100_after_wr_nofill", n, 32'd0);

        // A write to an uncached word does not allocate a line.
        do_write(32'h200, 32'hCAFE_F00D, 1'b0, w);
        mem_lat = 2;
        do_read(32'h200, d, w, n);
        check("r200_data", d, 32'hCAFE_F00D);
        check("r200_fill", n, 32'd3);

        // Three reads to the same index with alternating tags each miss.
        mem_lat = 1;
        do_read(32'h000, d, w, n);
        check("r000_fill", n, 32'd2);
        do_read(32'h100, d, w, n);
        check("r100_refill", n, 32'd2);
        check("r100_refill_data", d, 32'h1234_5678);
        do_read(32'h000, d, w, n);
        check("r000_refill", n, 32'd2);

        // Another index, a slow write hit, and rd and wr asserted together.
        do_read(32'h1234, d, w, n);
        mem_lat = 2;
        do_write(32'h1234, 32'h0BAD_CAFE, 1'b0, w);
        check("w1234_waits", w, 32'd3);
        do_write(32'h1234, 32'h5555_AAAA, 1'b1, w);
        do_read(32'h1234, d, w, n);
        check("r1234_data", d, 32'h5555_AAAA);
        check("r1234_hit", n, 32'd0);

        // Assert reset in the second FILL cycle; the fill is abandoned.
        mem_lat = 5;
        cache_addr = 32'h0340;
        cache_rd = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("fill_c1_rd", {31'd0, mem_rd}, 32'd1);
        @(negedge clock);
        check("fill_c2_rd", {31'd0, mem_rd}, 32'd1);
        #1;
        reset = 1'b1;
        cache_rd = 1'b0;
        @(posedge clock); #1;
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("abort_waitreq", {31'd0, cache_waitrequest}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        mem_lat = 1;
        do_read(32'h0340, d, w, n);
        check("reread_misses", n, 32'd2);
        do_read(32'h100, d, w, n);
        check("post_rst_r100_miss", n, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte-address width on both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width on both ports.
REQ-003 SHALL have parameter INDEX_BITS, default 6: log2 of line count (64 one-word lines).
REQ-004 SHALL have port clock, input, 1: sole clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports cache_addr input ADDR_WIDTH, cache_rd input 1, cache_wr input 1, cache_wr_data input DATA_WIDTH: pipeline-side request.
REQ-007 SHALL have ports cache_data output DATA_WIDTH and cache_waitrequest output 1: pipeline-side response.
REQ-008 SHALL have ports mem_addr output ADDR_WIDTH, mem_rd output 1, mem_wr output 1, mem_wr_data output DATA_WIDTH: backing-memory request.
REQ-009 SHALL have ports mem_data input DATA_WIDTH and mem_waitrequest input 1: backing-memory response.
REQ-010 SHALL have ports hit_count output 32 and miss_count output 32: statistics.

Function
REQ-011 SHALL use the same protocol on both sides: a transfer completes in the cycle rd or wr is high and waitrequest is low; read data is valid in that cycle; the requester holds request signals stable while waitrequest is high.
REQ-012 SHALL be direct-mapped, one word per line: index = addr[INDEX_BITS+1:2], tag = addr[ADDR_WIDTH-1:INDEX_BITS+2], addr[1:0] ignored; storage is flops with per-line valid bit.
REQ-013 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-014 IDLE, cache_rd and hit: cache_waitrequest low combinationally, cache_data = line data, zero wait states, stay IDLE.
REQ-015 IDLE, cache_rd and miss: cache_waitrequest high, latch addr, go FILL.
REQ-016 FILL: mem_rd high, mem_addr = latched addr, cache_waitrequest high; on mem_waitrequest low write mem_data, tag, valid=1 into line, go IDLE; the retried read then hits (miss latency = memory latency + 2 cycles).
REQ-017 IDLE, cache_wr: cache_waitrequest high, latch addr and data, go WRITE.
REQ-018 WRITE: mem_wr high, mem_addr/mem_wr_data = latched values, cache_waitrequest = mem_waitrequest; on mem_waitrequest low update the line only if it hits (write-through, no-write-allocate), go IDLE.
REQ-019 cache_rd and cache_wr both high SHALL be treated as a write.
REQ-020 mem_rd and mem_wr SHALL never be high together and SHALL be low in IDLE.
REQ-021 cache_data SHALL be 0 whenever no read completes.
REQ-022 Two consecutive requests to the same index with different tags SHALL each miss; the fill SHALL replace the old line.

Reset
REQ-023 reset SHALL force state IDLE, clear all valid bits, drive cache_waitrequest, mem_rd, mem_wr low and mem_addr, mem_wr_data, cache_data, hit_count, miss_count to 0, from the next edge.
REQ-024 reset during FILL or WRITE SHALL abandon the memory transfer (mem_rd/mem_wr low after that edge) with no line update.

Configuration
REQ-025 With macro DCACHE_STATS_EN defined, hit_count SHALL increment once per completed read hit and miss_count once per FILL entry, both wrapping at 2^32.
REQ-026 Without DCACHE_STATS_EN, hit_count and miss_count SHALL be tied to 0 and the counters not built.

Verification
REQ-027 After reset, read 0x100, memory returns 0xDEADBEEF after 3 waits -> mem_rd held 4 cycles, then the retry completes with cache_data 0xDEADBEEF; miss_count=1, hit_count=1.
REQ-028 Read 0x100 again -> zero-wait completion, 0xDEADBEEF, no mem_rd; hit_count=2.
REQ-029 Write 0x12345678 to 0x100, mem_waitrequest low immediately -> one wait cycle, mem_wr with addr 0x100; subsequent read returns 0x12345678 with no fill.
REQ-030 Write to uncached 0x200 then read 0x200 -> write does not allocate; read misses and fills.
REQ-031 Read 0x000 then 0x100 (same index, INDEX_BITS=6) then 0x000 -> three misses, three fills.
REQ-032 Assert reset in cycle 2 of FILL -> mem_rd low next cycle; re-read of the same address misses.
